// File: rtl/nw_pkg.sv
// nw_pkg: shared symbol width, nucleotide/gap symbol codes and traversal FSM states
package nw_pkg;
  localparam int SYM_BITS = 3;
  typedef enum logic [SYM_BITS-1:0] {SYM_A, SYM_C, SYM_G, SYM_T, SYM_GAP} sym_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/seq_pair_reader_if.sv
// seq_pair_reader_if: sequence RAM read port (rd_en, addr_a/b, data_a/b) plus pair output (a, b, i_idx, j_idx, en_read) and downstream hold
interface seq_pair_reader_if #(parameter int ADDR_W = 4, parameter int SYM_W = 3);
  logic hold, rd_en, en_read;
  logic [ADDR_W-1:0] addr_a, addr_b, i_idx, j_idx;
  logic [SYM_W-1:0] data_a, data_b, a, b;
  modport master (input hold, data_a, data_b, output rd_en, addr_a, addr_b, a, b, en_read, i_idx, j_idx);
  modport slave (output hold, data_a, data_b, input rd_en, addr_a, addr_b, a, b, en_read, i_idx, j_idx);
endinterface

// File: rtl/pair_skid_buf.sv
// pair_skid_buf: one-entry holding slot for a RAM pair (a, b, i, j, last) caught under hold; load wins over drain
module pair_skid_buf #(
  parameter int ADDR_W = 4,
  parameter int SYM_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic              in_last,
  input  logic [SYM_W-1:0]  in_a,
  input  logic [SYM_W-1:0]  in_b,
  input  logic [ADDR_W-1:0] in_i,
  input  logic [ADDR_W-1:0] in_j,
  output logic              valid,
  output logic              out_last,
  output logic [SYM_W-1:0]  out_a,
  output logic [SYM_W-1:0]  out_b,
  output logic [ADDR_W-1:0] out_i,
  output logic [ADDR_W-1:0] out_j
);
  always_ff @(posedge clk)
    if (rst) {valid, out_last, out_a, out_b, out_i, out_j} <= '0;
    else if (load) {valid, out_last, out_a, out_b, out_i, out_j} <= {1'b1, in_last, in_a, in_b, in_i, in_j};
    else if (drain) valid <= 1'b0;
endmodule

// File: rtl/seq_pair_reader.sv
// seq_pair_reader: row-major (i,j) walk reading sequence RAMs A/B into registered pairs; ports clk, rst, start, busy, done, bus (RAM read port + pair output + hold)
module seq_pair_reader import nw_pkg::*; #(
  parameter int LEN_A = 8,
  parameter int LEN_B = 8,
  parameter int ADDR_W = 4,
  parameter int SYM_W = SYM_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  seq_pair_reader_if.master bus
);
  state_t state;
  logic [ADDR_W-1:0] i, j, pi, pj, s_i, s_j;
  logic [SYM_W-1:0] s_a, s_b;
  logic pend, pend_last, out_last, s_last, skid_v, issue, row_end, at_last;
  if (LEN_A < 1 || LEN_A > 2**ADDR_W || LEN_B < 1 || LEN_B > 2**ADDR_W) begin : g_len_chk
    $error("seq_pair_reader: LEN_A/LEN_B must be in 1..2**ADDR_W");
  end
  assign row_end = j == ADDR_W'(LEN_B - 1);
  assign at_last = row_end && i == ADDR_W'(LEN_A - 1);
  assign issue = state == RUN && !bus.hold;
  assign busy = state != IDLE;
  assign bus.rd_en = issue;
  assign bus.addr_a = i;
  assign bus.addr_b = j;
  // RAM data arriving while held has nowhere to go, so it parks here until hold drops
  pair_skid_buf #(.ADDR_W(ADDR_W), .SYM_W(SYM_W)) u_skid (
    .clk(clk), .rst(rst), .load(bus.hold && pend), .drain(!bus.hold && skid_v),
    .in_last(pend_last), .in_a(bus.data_a), .in_b(bus.data_b), .in_i(pi), .in_j(pj),
    .valid(skid_v), .out_last(s_last), .out_a(s_a), .out_b(s_b), .out_i(s_i), .out_j(s_j)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      {i, j, pi, pj, pend, pend_last, out_last, done} <= '0;
      {bus.en_read, bus.a, bus.b, bus.i_idx, bus.j_idx} <= '0;
    end else begin
      state <= state == IDLE ? (start ? RUN : IDLE) :
               state == RUN ? (issue && at_last ? DRAIN : RUN) :
               state == DRAIN ? (bus.en_read && out_last ? DONE : DRAIN) : IDLE;
      done <= state == DRAIN && bus.en_read && out_last;
      if (issue) begin
        j <= row_end ? '0 : j + 1'b1;
        i <= at_last ? '0 : row_end ? i + 1'b1 : i;
        pi <= i;
        pj <= j;
      end
      pend <= issue;
      pend_last <= issue && at_last;
      bus.en_read <= !bus.hold && (skid_v || pend);
      if (!bus.hold && skid_v)
        {out_last, bus.a, bus.b, bus.i_idx, bus.j_idx} <= {s_last, s_a, s_b, s_i, s_j};
      else if (!bus.hold && pend)
        {out_last, bus.a, bus.b, bus.i_idx, bus.j_idx} <= {pend_last, bus.data_a, bus.data_b, pi, pj};
    end
  // issue is blocked under hold, so a parked pair is always drained before new data lands
  always_ff @(posedge clk)
    if (!rst) assert (!(skid_v && pend && !bus.hold));
endmodule

// File: tb/tb_seq_pair_reader.sv
module tb_seq_pair_reader;
  import nw_pkg::*;
  typedef struct { int i; int j; int a; int b; } pair_t;
  typedef struct { string name; int hold_from; int hold_len; int restart; int rst_at; int exp_done; } case_t;

  logic clk = 0, rst = 1, start = 0, start1 = 0;
  logic busy, done, busy1, done1;
  int errors = 0, checks = 0;
  pair_t exp_pairs[6];
  case_t cases[6];
  pair_t q[$];
  logic [2:0] ram_a [0:1];
  logic [2:0] ram_b [0:2];

  always #5 clk = ~clk;

  seq_pair_reader_if #(.ADDR_W(4), .SYM_W(3)) bus ();
  seq_pair_reader_if #(.ADDR_W(4), .SYM_W(3)) bus1 ();

  seq_pair_reader #(.LEN_A(2), .LEN_B(3), .ADDR_W(4), .SYM_W(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus));
  seq_pair_reader #(.LEN_A(1), .LEN_B(1), .ADDR_W(4), .SYM_W(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .bus(bus1));

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.data_a <= ram_a[bus.addr_a[0]];
      bus.data_b <= ram_b[bus.addr_b[1:0]];
    end
    if (bus1.rd_en) begin
      bus1.data_a <= SYM_G;
      bus1.data_b <= SYM_T;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pack(input int i, input int j, input int a, input int b);
    return (i << 10) | (j << 6) | (a << 3) | b;
  endfunction

  task automatic run_case(input case_t c);
    int done_k, pulses, dones, hold_bad;
    pair_t p;
    done_k = -1; pulses = 0; dones = 0; hold_bad = 0;
    q.delete();
    foreach (exp_pairs[n]) q.push_back(exp_pairs[n]);
    for (int k = 0; k < 30; k++) begin
      start = (k == 0) || (k == c.restart);
      bus.hold = k >= c.hold_from && k < c.hold_from + c.hold_len;
      rst = k == c.rst_at;
      @(negedge clk);
      if (bus.hold && bus.rd_en) hold_bad++;
      if (k > c.hold_from && k <= c.hold_from + c.hold_len && bus.en_read) hold_bad++;
      if (c.rst_at >= 0 && k == c.rst_at + 1) begin
        chk({c.name, " outputs after rst"},
            {bus.en_read, bus.rd_en, busy, done, u_dut.skid_v, bus.a, bus.b, bus.i_idx, bus.j_idx}, 0);
        @(posedge clk); #1;
        break;
      end
      if (bus.en_read) begin
        pulses++;
        if (q.size() == 0) chk({c.name, " extra pair"}, pack(bus.i_idx, bus.j_idx, bus.a, bus.b), -1);
        else begin
          p = q.pop_front();
          chk({c.name, " pair"}, pack(bus.i_idx, bus.j_idx, bus.a, bus.b), pack(p.i, p.j, p.a, p.b));
        end
      end
      if (done) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k == done_k + 1) chk({c.name, " busy after done"}, busy, 0);
      @(posedge clk); #1;
    end
    start = 0; bus.hold = 0; rst = 0;
    if (c.rst_at < 0) begin
      chk({c.name, " pulses"}, pulses, 6);
      chk({c.name, " done cycle"}, done_k, c.exp_done);
      chk({c.name, " done count"}, dones, 1);
      chk({c.name, " hold violations"}, hold_bad, 0);
      chk({c.name, " leftover"}, q.size(), 0);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_len1(input int h);
    int en_k, d_k, en_n;
    en_k = -1; d_k = -1; en_n = 0;
    for (int k = 0; k < 10; k++) begin
      start1 = k == 0;
      bus1.hold = h != 0 && k == 2;
      @(negedge clk);
      if (bus1.en_read) begin
        en_n++;
        en_k = k;
        chk("len1 pair", pack(bus1.i_idx, bus1.j_idx, bus1.a, bus1.b), pack(0, 0, SYM_G, SYM_T));
      end
      if (done1 && d_k < 0) d_k = k;
      @(posedge clk); #1;
    end
    start1 = 0; bus1.hold = 0;
    chk("len1 en_read cycle", en_k, 3 + h);
    chk("len1 en_read count", en_n, 1);
    chk("len1 done cycle", d_k, 4 + h);
  endtask

  initial begin
    ram_a[0] = SYM_A; ram_a[1] = SYM_C;
    ram_b[0] = SYM_C; ram_b[1] = SYM_C; ram_b[2] = SYM_G;
    exp_pairs[0] = '{0, 0, SYM_A, SYM_C};
    exp_pairs[1] = '{0, 1, SYM_A, SYM_C};
    exp_pairs[2] = '{0, 2, SYM_A, SYM_G};
    exp_pairs[3] = '{1, 0, SYM_C, SYM_C};
    exp_pairs[4] = '{1, 1, SYM_C, SYM_C};
    exp_pairs[5] = '{1, 2, SYM_C, SYM_G};
    cases[0] = '{"plain", 99, 0, -1, -1, 9};
    cases[1] = '{"hold1", 4, 1, -1, -1, 10};
    cases[2] = '{"hold5", 2, 5, -1, -1, 14};
    cases[3] = '{"restart", 99, 0, 5, -1, 9};
    cases[4] = '{"reset", 99, 0, -1, 5, 0};
    cases[5] = '{"after_reset", 99, 0, -1, -1, 9};
    bus.hold = 0; bus1.hold = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset state", {bus.en_read, bus.rd_en, busy, done, bus.a, bus.b, bus.i_idx, bus.j_idx}, 0);
    chk("reset state len1", {bus1.en_read, bus1.rd_en, busy1, done1}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    foreach (cases[n]) run_case(cases[n]);
    run_len1(0);
    run_len1(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
